// File: rtl/instr_fetch_unit.sv
// Instruction fetch unit: owns the PC, issues addresses to a single-cycle-latency
// instruction memory, and hands instructions to decode with stall/redirect support.
module instr_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h00000000,
  parameter logic [31:0] NOP_WORD = 32'h00000033,
  parameter logic [31:0] ERR_WORD = 32'hDEADBEEF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall_i,
  input  logic        redirect_i,
  input  logic [31:0] redirect_pc_i,
  output logic [31:0] imem_addr_o,
  input  logic [31:0] imem_rdata_i,
  output logic [31:0] instr_o,
  output logic [31:0] pc_o,
  output logic        valid_o,
  output logic        fault_o
);

  typedef enum logic {RUN, HOLD} state_t;

  state_t      state, state_nxt;
  logic [31:0] pc_q, req_pc_q, hold_instr_q, hold_pc_q;
  logic        req_valid_q;
  logic        advance, capture;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= RUN;
    else     state <= state_nxt;
  end

  // Redirect beats everything, including a stall held in HOLD.
  always_comb begin
    state_nxt = state;
    advance   = 1'b0;
    capture   = 1'b0;
    if (redirect_i) begin
      state_nxt = RUN;
    end else begin
      case (state)
        RUN: begin
          if (!req_valid_q) begin
            advance = 1'b1;
          end else if (stall_i) begin
            capture   = 1'b1;
            state_nxt = HOLD;
          end else begin
            advance = 1'b1;
          end
        end
        HOLD: begin
          if (!stall_i) begin
            advance   = 1'b1;
            state_nxt = RUN;
          end
        end
        default: state_nxt = RUN;
      endcase
    end
  end

  always_comb begin
    valid_o = 1'b0;
    instr_o = NOP_WORD;
    pc_o    = req_pc_q;
    if (state == HOLD) begin
      pc_o = hold_pc_q;
      if (!redirect_i) begin
        valid_o = 1'b1;
        instr_o = hold_instr_q;
      end
    end else if (req_valid_q && !redirect_i) begin
      valid_o = 1'b1;
      instr_o = imem_rdata_i;
    end
    fault_o = valid_o && (instr_o == ERR_WORD);
  end

  assign imem_addr_o = pc_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_q         <= RESET_PC;
      req_valid_q  <= 1'b0;
      req_pc_q     <= 32'h0;
      hold_instr_q <= 32'h0;
      hold_pc_q    <= 32'h0;
    end else if (redirect_i) begin
      pc_q        <= {redirect_pc_i[31:2], 2'b00};
      req_valid_q <= 1'b0;
    end else if (advance) begin
      pc_q        <= pc_q + 32'd4;
      req_pc_q    <= pc_q;
      req_valid_q <= 1'b1;
    end else if (capture) begin
      // The in-flight word for pc_q is dropped; pc_q is reissued on release.
      hold_instr_q <= imem_rdata_i;
      hold_pc_q    <= req_pc_q;
      req_valid_q  <= 1'b0;
    end
  end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Bench for instr_fetch_unit: cycle table of stimulus/expected outputs plus an
// in-order scoreboard of consumed instructions.
module tb_instr_fetch_unit;

  localparam logic [31:0] NOP = 32'h00000033;
  localparam logic [31:0] ERR = 32'hDEADBEEF;

  logic        clk = 1'b0;
  logic        rst;
  logic        stall, redirect;
  logic [31:0] redirect_pc;
  logic [31:0] imem_addr, imem_rdata, instr, pc;
  logic        valid, fault;

  int n_vec = 0;
  int n_err = 0;

  logic [31:0] exp_q[$];

  instr_fetch_unit dut (
    .clk          (clk),
    .rst          (rst),
    .stall_i      (stall),
    .redirect_i   (redirect),
    .redirect_pc_i(redirect_pc),
    .imem_addr_o  (imem_addr),
    .imem_rdata_i (imem_rdata),
    .instr_o      (instr),
    .pc_o         (pc),
    .valid_o      (valid),
    .fault_o      (fault)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    case (a)
      32'h00: mem_word = 32'h3E802403;
      32'h04: mem_word = 32'h3EC02483;
      32'h08: mem_word = 32'h00000033;
      32'h18: mem_word = 32'h00940533;
      32'h1C: mem_word = 32'h409405B3;
      32'h28: mem_word = 32'hDEADBEEF;
      default: mem_word = 32'h00000013 | (a << 10);
    endcase
  endfunction

  always @(posedge clk) imem_rdata <= rst ? 32'h0 : mem_word(imem_addr);

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic push_seq(input logic [31:0] start, input int n);
    for (int k = 0; k < n; k++) exp_q.push_back(start + 32'(4 * k));
  endtask

  // Scoreboard: every consumed instruction must be the next expected PC, in order.
  always @(negedge clk) begin
    if (!rst && valid && !stall && !redirect) begin
      if (exp_q.size() == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL sb_unexpected: got pc %h, expected no consumption", pc);
      end else begin
        logic [31:0] e;
        e = exp_q.pop_front();
        chk("sb_pc", pc, e);
        chk("sb_instr", instr, mem_word(e));
        chk("sb_fault", {31'b0, fault}, {31'b0, mem_word(e) == ERR});
      end
    end
  end

  typedef struct {
    logic        stall;
    logic        redir;
    logic [31:0] rpc;
    logic        ev;
    logic [31:0] epc;
    logic [31:0] einstr;
    logic [31:0] eaddr;
    logic [31:0] push_pc;
    int          push_n;
  } vec_t;

  function automatic vec_t v(input logic s, input logic r, input logic [31:0] rp,
                             input logic ev, input logic [31:0] epc, input logic [31:0] ei,
                             input logic [31:0] ea, input logic [31:0] pp, input int pn);
    vec_t t;
    t.stall = s; t.redir = r; t.rpc = rp; t.ev = ev; t.epc = epc;
    t.einstr = ei; t.eaddr = ea; t.push_pc = pp; t.push_n = pn;
    return t;
  endfunction

  vec_t tbl[26];

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    tbl[0]  = v(0, 0, 0, 0, 32'h00, NOP, 32'h00, 32'h00, 2);
    tbl[1]  = v(0, 0, 0, 1, 32'h00, 32'h3E802403, 32'h04, 0, 0);
    tbl[2]  = v(1, 0, 0, 1, 32'h04, 32'h3EC02483, 32'h08, 0, 0);
    tbl[3]  = v(1, 0, 0, 1, 32'h04, 32'h3EC02483, 32'h08, 0, 0);
    tbl[4]  = v(1, 0, 0, 1, 32'h04, 32'h3EC02483, 32'h08, 0, 0);
    tbl[5]  = v(0, 0, 0, 1, 32'h04, 32'h3EC02483, 32'h08, 0, 0);
    tbl[6]  = v(1, 0, 0, 1, 32'h08, 32'h00000033, 32'h0C, 0, 0);
    tbl[7]  = v(1, 1, 32'h1A, 0, 32'h00, NOP, 32'h0C, 32'h18, 6);
    tbl[8]  = v(0, 0, 0, 0, 32'h00, NOP, 32'h18, 0, 0);
    tbl[9]  = v(0, 0, 0, 1, 32'h18, 32'h00940533, 32'h1C, 0, 0);
    tbl[10] = v(0, 0, 0, 1, 32'h1C, 32'h409405B3, 32'h20, 0, 0);
    tbl[11] = v(0, 0, 0, 1, 32'h20, mem_word(32'h20), 32'h24, 0, 0);
    tbl[12] = v(0, 0, 0, 1, 32'h24, mem_word(32'h24), 32'h28, 0, 0);
    tbl[13] = v(0, 0, 0, 1, 32'h28, 32'hDEADBEEF, 32'h2C, 0, 0);
    tbl[14] = v(0, 0, 0, 1, 32'h2C, mem_word(32'h2C), 32'h30, 0, 0);
    tbl[15] = v(1, 0, 0, 1, 32'h30, mem_word(32'h30), 32'h34, 0, 0);
    tbl[16] = v(1, 1, 32'h08, 0, 32'h00, NOP, 32'h34, 32'h08, 2);
    tbl[17] = v(1, 0, 0, 0, 32'h00, NOP, 32'h08, 0, 0);
    tbl[18] = v(0, 0, 0, 1, 32'h08, 32'h00000033, 32'h0C, 0, 0);
    tbl[19] = v(0, 0, 0, 1, 32'h0C, mem_word(32'h0C), 32'h10, 0, 0);
    tbl[20] = v(0, 1, 32'hFFFFFFFE, 0, 32'h00, NOP, 32'h14, 32'hFFFFFFFC, 2);
    tbl[21] = v(0, 0, 0, 0, 32'h00, NOP, 32'hFFFFFFFC, 0, 0);
    tbl[22] = v(0, 0, 0, 1, 32'hFFFFFFFC, mem_word(32'hFFFFFFFC), 32'h00, 0, 0);
    tbl[23] = v(0, 0, 0, 1, 32'h00, 32'h3E802403, 32'h04, 0, 0);
    tbl[24] = v(1, 0, 0, 1, 32'h04, 32'h3EC02483, 32'h08, 0, 0);
    tbl[25] = v(1, 0, 0, 1, 32'h04, 32'h3EC02483, 32'h08, 0, 0);

    rst = 1'b1; stall = 1'b0; redirect = 1'b0; redirect_pc = 32'h0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_valid", {31'b0, valid}, 32'h0);
    chk("rst_instr", instr, NOP);
    chk("rst_pc", pc, 32'h0);
    chk("rst_addr", imem_addr, 32'h0);
    chk("rst_fault", {31'b0, fault}, 32'h0);
    @(posedge clk);
    #1 rst = 1'b0;

    for (int i = 0; i < 26; i++) begin
      stall       = tbl[i].stall;
      redirect    = tbl[i].redir;
      redirect_pc = tbl[i].rpc;
      if (tbl[i].push_n > 0) push_seq(tbl[i].push_pc, tbl[i].push_n);
      @(negedge clk);
      chk($sformatf("c%0d_valid", i), {31'b0, valid}, {31'b0, tbl[i].ev});
      chk($sformatf("c%0d_instr", i), instr, tbl[i].einstr);
      chk($sformatf("c%0d_addr", i), imem_addr, tbl[i].eaddr);
      chk($sformatf("c%0d_fault", i), {31'b0, fault},
          {31'b0, tbl[i].ev && tbl[i].einstr == ERR});
      if (tbl[i].ev) chk($sformatf("c%0d_pc", i), pc, tbl[i].epc);
      @(posedge clk);
      #1;
    end
    redirect = 1'b0;
    chk("sb_drained", exp_q.size(), 32'h0);

    // Reset asserted mid-stall must clear outputs without waiting for an edge.
    #2 rst = 1'b1;
    #1;
    chk("arst_valid", {31'b0, valid}, 32'h0);
    chk("arst_instr", instr, NOP);
    chk("arst_addr", imem_addr, 32'h0);
    chk("arst_pc", pc, 32'h0);
    repeat (2) @(posedge clk);
    stall = 1'b0;
    #1 rst = 1'b0;
    push_seq(32'h0, 2);
    @(negedge clk);
    chk("rr_c0_valid", {31'b0, valid}, 32'h0);
    chk("rr_c0_addr", imem_addr, 32'h0);
    @(posedge clk);
    @(negedge clk);
    chk("rr_c1_valid", {31'b0, valid}, 32'h1);
    chk("rr_c1_pc", pc, 32'h0);
    chk("rr_c1_instr", instr, 32'h3E802403);
    @(posedge clk);
    @(negedge clk);
    chk("rr_c2_pc", pc, 32'h4);
    chk("rr_c2_instr", instr, 32'h3EC02483);
    @(posedge clk);
    #1;
    chk("sb_final_drained", exp_q.size(), 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
